// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shift/rotate unit: operation
// encodings and an elaboration-time ceil(log2) helper.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRA = 2'b01,
        SH_ROR = 2'b10,
        SH_ROL = 2'b11
    } shift_op_t;

    // ceil(log2(v)); returns 0 for v <= 1
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational mux level of the shifter: when sel_i is set the data
// moves by DIST positions according to op_i, otherwise it passes through.
module shift_level
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             sign_i,
    input  shift_op_t        op_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] data_o
);

    // select shifted/rotated form for this level's distance
    always_comb begin
        data_o = data_i;
        if (sel_i) begin
            unique case (op_i)
                SH_SLL: data_o = {data_i[WIDTH-DIST-1:0], {DIST{1'b0}}};
                SH_SRA: data_o = {{DIST{sign_i}}, data_i[WIDTH-1:DIST]};
                SH_ROR: data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
                SH_ROL: data_o = {data_i[WIDTH-DIST-1:0], data_i[WIDTH-1:WIDTH-DIST]};
                default: data_o = data_i;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined SLL/SRA/ROR/ROL unit with valid/ready flow control.
// The log2(WIDTH) mux levels are split LEVELS_PER_STAGE per register stage.
// Optional feature macro: SHIFT_FLAGS_EN (registered zero/negative flags).
module shift_pipe
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH            = 16,
    parameter int unsigned LEVELS_PER_STAGE = 2,
    parameter int unsigned TAG_W            = 4,
    localparam int unsigned SHAMT_W = clog2(WIDTH),
    localparam int unsigned NSTAGE  = (SHAMT_W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_z,
    output logic               out_n
);

    localparam int unsigned LPS = LEVELS_PER_STAGE;

    logic               valid_q [NSTAGE];
    logic               valid_d [NSTAGE];
    shift_op_t          op_q    [NSTAGE];
    shift_op_t          op_d    [NSTAGE];
    logic [WIDTH-1:0]   data_q  [NSTAGE];
    logic [WIDTH-1:0]   data_d  [NSTAGE];
    logic               sign_q  [NSTAGE];
    logic               sign_d  [NSTAGE];
    logic [SHAMT_W-1:0] shamt_q [NSTAGE];
    logic [SHAMT_W-1:0] shamt_d [NSTAGE];
    logic [TAG_W-1:0]   tag_q   [NSTAGE];
    logic [TAG_W-1:0]   tag_d   [NSTAGE];

    // result of each stage's mux levels, loaded into that stage's register
    logic [WIDTH-1:0]   stage_res [NSTAGE];
    logic [NSTAGE:0]    rdy;

    // Level j belongs to stage j/LPS; the first level of a stage reads the
    // previous stage register (or the input port for stage 0), later levels
    // chain from the level before.
    for (genvar j = 0; j < SHAMT_W; j++) begin : g_lvl
        localparam int unsigned K = j / LPS;
        logic [WIDTH-1:0] d_in;
        logic [WIDTH-1:0] d_out;
        logic             sg;
        shift_op_t        op;
        logic             sel;

        if (K == 0) begin : g_src_in
            assign sg  = in_data[WIDTH-1];
            assign op  = shift_op_t'(in_op);
            assign sel = in_shamt[j];
        end else begin : g_src_reg
            assign sg  = sign_q[K-1];
            assign op  = op_q[K-1];
            assign sel = shamt_q[K-1][j];
        end

        if (j % LPS != 0) begin : g_chain
            assign d_in = g_lvl[j-1].d_out;
        end else if (K == 0) begin : g_head_in
            assign d_in = in_data;
        end else begin : g_head_reg
            assign d_in = data_q[K-1];
        end

        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << j)
        ) u_level (
            .data_i (d_in),
            .sign_i (sg),
            .op_i   (op),
            .sel_i  (sel),
            .data_o (d_out)
        );
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int unsigned LAST =
            (((k + 1) * LPS) < SHAMT_W) ? ((k + 1) * LPS - 1) : (SHAMT_W - 1);
        assign stage_res[k] = g_lvl[LAST].d_out;
    end

    // backward ready chain: a stage can load when empty or when it drains
    always_comb begin
        rdy         = '0;
        rdy[NSTAGE] = out_ready;
        for (int unsigned i = NSTAGE; i > 0; i--) begin
            rdy[i-1] = ~valid_q[i-1] | rdy[i];
        end
    end

    assign in_ready = ~rst & rdy[0];

    // stage next-state: load from upstream when ready, otherwise hold
    always_comb begin
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            valid_d[k] = valid_q[k];
            op_d[k]    = op_q[k];
            data_d[k]  = data_q[k];
            sign_d[k]  = sign_q[k];
            shamt_d[k] = shamt_q[k];
            tag_d[k]   = tag_q[k];
        end
        if (rdy[0]) begin
            valid_d[0] = in_valid;
            op_d[0]    = shift_op_t'(in_op);
            data_d[0]  = stage_res[0];
            sign_d[0]  = in_data[WIDTH-1];
            shamt_d[0] = in_shamt;
            tag_d[0]   = in_tag;
        end
        for (int unsigned k = 1; k < NSTAGE; k++) begin
            if (rdy[k]) begin
                valid_d[k] = valid_q[k-1];
                op_d[k]    = op_q[k-1];
                data_d[k]  = stage_res[k];
                sign_d[k]  = sign_q[k-1];
                shamt_d[k] = shamt_q[k-1];
                tag_d[k]   = tag_q[k-1];
            end
        end
    end

    // stage registers with synchronous reset clearing every stage
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            if (rst) begin
                valid_q[k] <= 1'b0;
                op_q[k]    <= SH_SLL;
                data_q[k]  <= '0;
                sign_q[k]  <= 1'b0;
                shamt_q[k] <= '0;
                tag_q[k]   <= '0;
            end else begin
                valid_q[k] <= valid_d[k];
                op_q[k]    <= op_d[k];
                data_q[k]  <= data_d[k];
                sign_q[k]  <= sign_d[k];
                shamt_q[k] <= shamt_d[k];
                tag_q[k]   <= tag_d[k];
            end
        end
    end

    assign out_valid = valid_q[NSTAGE-1];
    assign out_data  = data_q[NSTAGE-1];
    assign out_tag   = tag_q[NSTAGE-1];

`ifdef SHIFT_FLAGS_EN
    logic z_q, z_d, n_q, n_d;

    // flags follow the final-stage data load so they stay aligned with it
    always_comb begin
        z_d = z_q;
        n_d = n_q;
        if (rdy[NSTAGE-1]) begin
            z_d = (stage_res[NSTAGE-1] == '0);
            n_d = stage_res[NSTAGE-1][WIDTH-1];
        end
    end

    // flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            z_q <= 1'b0;
            n_q <= 1'b0;
        end else begin
            z_q <= z_d;
            n_q <= n_d;
        end
    end

    assign out_z = z_q;
    assign out_n = n_q;
`else
    assign out_z = 1'b0;
    assign out_n = 1'b0;
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// Directed self-checking bench for shift_pipe (WIDTH=16, LPS=2, NSTAGE=2).
// Flag expectations follow SHIFT_FLAGS_EN.
module tb_shift_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_data;
    logic [3:0]  in_shamt;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_tag;
    logic        out_z;
    logic        out_n;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    shift_pipe #(
        .WIDTH            (16),
        .LEVELS_PER_STAGE (2),
        .TAG_W            (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_z     (out_z),
        .out_n     (out_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] d,
                         input logic [3:0] sh, input logic [3:0] tg);
        in_valid = v;
        in_op    = op;
        in_data  = d;
        in_shamt = sh;
        in_tag   = tg;
    endtask

    task automatic chk_flags(input string name, input logic [15:0] exp);
        logic ez, en;
`ifdef SHIFT_FLAGS_EN
        ez = (exp == 16'h0000);
        en = exp[15];
`else
        ez = 1'b0;
        en = 1'b0;
`endif
        chk({name, ".z"}, {31'd0, out_z}, {31'd0, ez});
        chk({name, ".n"}, {31'd0, out_n}, {31'd0, en});
    endtask

    // single operation with out_ready=1: result must appear exactly 2 cycles after accept
    task automatic run_one(input string name, input logic [1:0] op, input logic [15:0] d,
                           input logic [3:0] sh, input logic [3:0] tg, input logic [15:0] exp);
        out_ready = 1'b1;
        drive(1'b1, op, d, sh, tg);
        @(negedge clk);
        chk({name, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        next_cycle();
        drive(1'b0, 2'b00, 16'h0000, 4'h0, 4'h0);
        @(negedge clk);
        chk({name, ".early"}, {31'd0, out_valid}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk({name, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, ".data"}, {16'd0, out_data}, {16'd0, exp});
        chk({name, ".tag"}, {28'd0, out_tag}, {28'd0, tg});
        chk_flags(name, exp);
        next_cycle();
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 16'h0000, 4'h0, 4'h0);

        // reset state
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.out_data", {16'd0, out_data}, 32'd0);
        chk("rst.out_tag", {28'd0, out_tag}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst.z", {31'd0, out_z}, 32'd0);
        chk("rst.n", {31'd0, out_n}, 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rel.in_ready", {31'd0, in_ready}, 32'd1);
        next_cycle();

        // single operations, latency and mode rules
        run_one("ror1", OP_ROR, 16'h8001, 4'd1, 4'd5, 16'hC000);
        run_one("sra15", OP_SRA, 16'h8000, 4'd15, 4'd1, 16'hFFFF);
        run_one("sll15", OP_SLL, 16'h0001, 4'd15, 4'd2, 16'h8000);
        run_one("rol4", OP_ROL, 16'h8001, 4'd4, 4'd3, 16'h0018);
        run_one("sra3", OP_SRA, 16'h7FFF, 4'd3, 4'd4, 16'h0FFF);
        run_one("sra5", OP_SRA, 16'h9000, 4'd5, 4'd6, 16'hFC80);
        run_one("ror9", OP_ROR, 16'h1234, 4'd9, 4'd7, 16'h1A09);
        run_one("z0.sll", OP_SLL, 16'hA5C3, 4'd0, 4'd8, 16'hA5C3);
        run_one("z0.sra", OP_SRA, 16'hA5C3, 4'd0, 4'd9, 16'hA5C3);
        run_one("z0.ror", OP_ROR, 16'hA5C3, 4'd0, 4'd10, 16'hA5C3);
        run_one("z0.rol", OP_ROL, 16'hA5C3, 4'd0, 4'd11, 16'hA5C3);
        run_one("flag.z", OP_SLL, 16'h8000, 4'd1, 4'd12, 16'h0000);
        run_one("flag.n", OP_ROR, 16'h0001, 4'd1, 4'd13, 16'h8000);

        // backpressure: four ops, out_ready low during cycles 3..5
        // cycle 1: offer A
        drive(1'b1, OP_SLL, 16'h0001, 4'd1, 4'd1);
        @(negedge clk);
        chk("bp.c1.in_ready", {31'd0, in_ready}, 32'd1);
        next_cycle();
        // cycle 2: offer B
        drive(1'b1, OP_SLL, 16'h0001, 4'd2, 4'd2);
        @(negedge clk);
        chk("bp.c2.in_ready", {31'd0, in_ready}, 32'd1);
        next_cycle();
        // cycle 3: offer C, consumer stalls; pipeline full with A,B
        drive(1'b1, OP_SLL, 16'h0001, 4'd3, 4'd3);
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp.c3.in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp.c3.valid", {31'd0, out_valid}, 32'd1);
        chk("bp.c3.data", {16'd0, out_data}, 32'h0002);
        next_cycle();
        @(negedge clk);
        chk("bp.c4.in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp.c4.data", {16'd0, out_data}, 32'h0002);
        chk("bp.c4.tag", {28'd0, out_tag}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("bp.c5.data", {16'd0, out_data}, 32'h0002);
        next_cycle();
        // cycle 6: consumer resumes; drain and accept in the same cycle
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.c6.in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp.c6.data", {16'd0, out_data}, 32'h0002);
        chk("bp.c6.tag", {28'd0, out_tag}, 32'd1);
        next_cycle();
        // cycle 7: offer D, B at output
        drive(1'b1, OP_SLL, 16'h0001, 4'd4, 4'd4);
        @(negedge clk);
        chk("bp.c7.valid", {31'd0, out_valid}, 32'd1);
        chk("bp.c7.data", {16'd0, out_data}, 32'h0004);
        chk("bp.c7.tag", {28'd0, out_tag}, 32'd2);
        next_cycle();
        drive(1'b0, 2'b00, 16'h0000, 4'h0, 4'h0);
        @(negedge clk);
        chk("bp.c8.data", {16'd0, out_data}, 32'h0008);
        chk("bp.c8.tag", {28'd0, out_tag}, 32'd3);
        next_cycle();
        @(negedge clk);
        chk("bp.c9.valid", {31'd0, out_valid}, 32'd1);
        chk("bp.c9.data", {16'd0, out_data}, 32'h0010);
        chk("bp.c9.tag", {28'd0, out_tag}, 32'd4);
        next_cycle();
        @(negedge clk);
        chk("bp.c10.valid", {31'd0, out_valid}, 32'd0);
        next_cycle();

        // reset with two operations in flight
        drive(1'b1, OP_ROR, 16'h00FF, 4'd4, 4'd9);
        next_cycle();
        drive(1'b1, OP_ROL, 16'h00FF, 4'd4, 4'd10);
        next_cycle();
        drive(1'b0, 2'b00, 16'h0000, 4'h0, 4'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst.in_ready", {31'd0, in_ready}, 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst.valid", {31'd0, out_valid}, 32'd0);
        chk("mrst.data", {16'd0, out_data}, 32'd0);
        chk("mrst.tag", {28'd0, out_tag}, 32'd0);
        chk("mrst.in_ready", {31'd0, in_ready}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("mrst.stale1", {31'd0, out_valid}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("mrst.stale2", {31'd0, out_valid}, 32'd0);
        next_cycle();

        // normal operation resumes after the mid-flight reset
        run_one("post", OP_ROL, 16'h000F, 4'd12, 4'd14, 16'hF000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
